// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: reusable valid/ready pipeline stage with flush, optional skid entry and stall counter
module pipe_stage_reg #(
   parameter int PAYLOAD_WIDTH = 64,
   parameter int CTRL_WIDTH    = 4,
   parameter int SKID          = 1,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                     cpu_clk,
   input  logic                     cpu_rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [PAYLOAD_WIDTH-1:0] in_payload,
   input  logic [CTRL_WIDTH-1:0]    in_ctrl,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [PAYLOAD_WIDTH-1:0] out_payload,
   output logic [CTRL_WIDTH-1:0]    out_ctrl,
   input  logic                     stat_clr,
   output logic [CNT_WIDTH-1:0]     stall_cnt
);
   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
   state_t state, state_nx;
   logic [PAYLOAD_WIDTH-1:0] m_payload, s_payload;
   logic [CTRL_WIDTH-1:0] m_ctrl, s_ctrl;
   logic accept, consume, load_m_in, load_m_s, load_s;
   assign out_valid   = state != EMPTY;
   assign out_payload = m_payload;
   assign out_ctrl    = m_ctrl;
   assign in_ready    = !cpu_rst && (SKID != 0 ? state != TWO : (out_ready || !out_valid));
   assign accept      = in_valid && in_ready;
   assign consume     = out_valid && out_ready;
   // next occupancy and which register loads from where; flush overrides everything
   always_comb begin
      state_nx  = state;
      load_m_in = 1'b0;
      load_m_s  = 1'b0;
      load_s    = 1'b0;
      case (state)
         EMPTY: if (accept) begin
            state_nx  = ONE;
            load_m_in = 1'b1;
         end
         ONE: if (accept && consume) load_m_in = 1'b1;
            else if (accept) begin
               state_nx = TWO;
               load_s   = 1'b1;
            end
            else if (consume) state_nx = EMPTY;
         TWO: if (consume) begin
            state_nx = ONE;
            load_m_s = 1'b1;
         end
         default: state_nx = EMPTY;
      endcase
      if (flush) state_nx = EMPTY;
   end
   // state and data registers; ctrl of any register left empty is zeroed so bubbles carry no side effects
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         state     <= EMPTY;
         m_payload <= '0;
         s_payload <= '0;
         m_ctrl    <= '0;
         s_ctrl    <= '0;
      end else begin
         state     <= state_nx;
         m_payload <= load_m_in ? in_payload : load_m_s ? s_payload : m_payload;
         s_payload <= load_s ? in_payload : s_payload;
         m_ctrl    <= state_nx == EMPTY ? '0 : load_m_in ? in_ctrl : load_m_s ? s_ctrl : m_ctrl;
         s_ctrl    <= state_nx == TWO ? (load_s ? in_ctrl : s_ctrl) : '0;
      end
   end
   // saturating count of back-pressured cycles; clear wins over increment, flush leaves it alone
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst || stat_clr) stall_cnt <= '0;
      else if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
   end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: checks a skid and a non-skid stage against a queue model plus directed vectors
module tb_pipe_stage_reg;
   logic cpu_clk, rst, fl, iv, ordy, clr;
   logic [15:0] ip;
   logic [3:0] ic;
   logic ir_s, ov_s, ir_r, ov_r;
   logic [15:0] op_s, op_r;
   logic [3:0] oc_s, oc_r, sc_s, sc_r;
   int checks = 0, errors = 0;

   typedef struct {
      logic [15:0] p;
      logic [3:0] c;
   } ent_t;
   ent_t fifo [2][2];
   int fill [2];
   int mcnt [2];

   typedef struct packed {
      logic rst, fl, iv;
      logic [15:0] p;
      logic [3:0] c;
      logic ordy, clr;
      logic e_ir, e_ov, chk_op;
      logic [15:0] e_op;
      logic [3:0] e_oc, e_sc;
   } vec_t;
   vec_t tbl [20];

   pipe_stage_reg #(.PAYLOAD_WIDTH(16), .CTRL_WIDTH(4), .SKID(1), .CNT_WIDTH(4)) u_s (
      .cpu_clk(cpu_clk), .cpu_rst(rst), .flush(fl), .in_valid(iv), .in_ready(ir_s),
      .in_payload(ip), .in_ctrl(ic), .out_valid(ov_s), .out_ready(ordy),
      .out_payload(op_s), .out_ctrl(oc_s), .stat_clr(clr), .stall_cnt(sc_s));

   pipe_stage_reg #(.PAYLOAD_WIDTH(16), .CTRL_WIDTH(4), .SKID(0), .CNT_WIDTH(4)) u_r (
      .cpu_clk(cpu_clk), .cpu_rst(rst), .flush(fl), .in_valid(iv), .in_ready(ir_r),
      .in_payload(ip), .in_ctrl(ic), .out_valid(ov_r), .out_ready(ordy),
      .out_payload(op_r), .out_ctrl(oc_r), .stat_clr(clr), .stall_cnt(sc_r));

   initial begin
      cpu_clk = 0;
      forever #5 cpu_clk = ~cpu_clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic m_ir(int k);
      return !rst && (k == 0 ? fill[k] < 2 : (fill[k] == 0 || ordy));
   endfunction

   task automatic cmp_model(input int k, input logic ir, input logic ov, input logic [15:0] op,
                            input logic [3:0] oc, input logic [3:0] sc);
      string n = k == 0 ? "skid" : "reg";
      chk({n, ".in_ready"}, 32'(ir), 32'(m_ir(k)));
      chk({n, ".out_valid"}, 32'(ov), 32'(fill[k] > 0));
      chk({n, ".out_ctrl"}, 32'(oc), fill[k] > 0 ? 32'(fifo[k][0].c) : 0);
      chk({n, ".stall_cnt"}, 32'(sc), 32'(mcnt[k]));
      if (fill[k] > 0) chk({n, ".out_payload"}, 32'(op), 32'(fifo[k][0].p));
   endtask

   task automatic drive(input logic r, input logic f, input logic v, input logic [15:0] p,
                        input logic [3:0] c, input logic o, input logic s);
      rst = r; fl = f; iv = v; ip = p; ic = c; ordy = o; clr = s;
      #1;
      cmp_model(0, ir_s, ov_s, op_s, oc_s, sc_s);
      cmp_model(1, ir_r, ov_r, op_r, oc_r, sc_r);
   endtask

   task automatic advance();
      for (int k = 0; k < 2; k++) begin
         logic acc, cons;
         acc  = iv && m_ir(k);
         cons = fill[k] > 0 && ordy;
         if (rst || clr) mcnt[k] = 0;
         else if (fill[k] > 0 && !ordy && mcnt[k] < 15) mcnt[k]++;
         if (rst || fl) fill[k] = 0;
         else begin
            if (cons) begin
               fifo[k][0] = fifo[k][1];
               fill[k]--;
            end
            if (acc) begin
               fifo[k][fill[k]] = '{ip, ic};
               fill[k]++;
            end
         end
      end
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic step(input logic r, input logic f, input logic v, input logic [15:0] p,
                       input logic [3:0] c, input logic o, input logic s);
      drive(r, f, v, p, c, o, s);
      advance();
   endtask

   initial begin
      fill = '{0, 0};
      mcnt = '{0, 0};
      //            rst fl iv  p        c     ordy clr  ir ov chk op       oc    sc
      tbl[0]  = '{1'b1, 1'b0, 1'b1, 16'h0011, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 4'h0, 4'd0};
      tbl[1]  = '{1'b1, 1'b0, 1'b1, 16'h0011, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 4'h0, 4'd0};
      tbl[2]  = '{1'b1, 1'b0, 1'b1, 16'h0011, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 4'h0, 4'd0};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 4'h0, 4'd0};
      tbl[4]  = '{1'b0, 1'b0, 1'b1, 16'h0001, 4'h1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 4'h0, 4'd0};
      tbl[5]  = '{1'b0, 1'b0, 1'b1, 16'h0002, 4'h2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0001, 4'h1, 4'd0};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0002, 4'h2, 4'd0};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 16'h000A, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 4'd0};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 16'h000B, 4'h6, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h000A, 4'h5, 4'd0};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 16'h000C, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h000A, 4'h5, 4'd1};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h000A, 4'h5, 4'd2};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h000B, 4'h6, 4'd2};
      tbl[12] = '{1'b0, 1'b0, 1'b1, 16'h000D, 4'h8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 4'd2};
      tbl[13] = '{1'b0, 1'b0, 1'b1, 16'h000E, 4'h9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h000D, 4'h8, 4'd2};
      tbl[14] = '{1'b0, 1'b1, 1'b1, 16'h00F0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h000D, 4'h8, 4'd3};
      tbl[15] = '{1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 4'd4};
      tbl[16] = '{1'b0, 1'b1, 1'b1, 16'h0077, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 4'd4};
      tbl[17] = '{1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 4'd4};
      tbl[18] = '{1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 4'd4};
      tbl[19] = '{1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 4'd0};
      rst = 1; fl = 0; iv = 0; ip = 0; ic = 0; ordy = 0; clr = 0;
      repeat (2) @(posedge cpu_clk);
      #1;
      for (int i = 0; i < 20; i++) begin
         drive(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].p, tbl[i].c, tbl[i].ordy, tbl[i].clr);
         chk($sformatf("tbl%0d.in_ready", i), 32'(ir_s), 32'(tbl[i].e_ir));
         chk($sformatf("tbl%0d.out_valid", i), 32'(ov_s), 32'(tbl[i].e_ov));
         chk($sformatf("tbl%0d.out_ctrl", i), 32'(oc_s), 32'(tbl[i].e_oc));
         chk($sformatf("tbl%0d.stall_cnt", i), 32'(sc_s), 32'(tbl[i].e_sc));
         if (tbl[i].chk_op) chk($sformatf("tbl%0d.out_payload", i), 32'(op_s), 32'(tbl[i].e_op));
         advance();
      end
      step(0, 0, 1, 16'h0055, 4'h2, 0, 0);
      repeat (20) step(0, 0, 0, 16'h0000, 4'h0, 0, 0);
      drive(0, 0, 0, 16'h0000, 4'h0, 0, 0);
      chk("sat.skid", 32'(sc_s), 15);
      chk("sat.reg", 32'(sc_r), 15);
      advance();
      step(0, 0, 0, 16'h0000, 4'h0, 0, 1);
      drive(0, 0, 0, 16'h0000, 4'h0, 0, 0);
      chk("clr.skid", 32'(sc_s), 0);
      advance();
      drive(0, 0, 0, 16'h0000, 4'h0, 0, 0);
      chk("resume.skid", 32'(sc_s), 1);
      advance();
      drive(0, 0, 1, 16'h0066, 4'h4, 0, 0);
      chk("reg.stall_ready", 32'(ir_r), 0);
      advance();
      drive(0, 0, 1, 16'h0066, 4'h4, 1, 0);
      chk("reg.resume_ready", 32'(ir_r), 1);
      advance();
      drive(0, 0, 0, 16'h0000, 4'h0, 1, 0);
      chk("reg.new_payload", 32'(op_r), 32'h66);
      chk("reg.new_valid", 32'(ov_r), 1);
      advance();
      step(0, 1, 0, 16'h0000, 4'h0, 1, 0);
      for (int i = 0; i < 400; i++)
         step($urandom_range(99) < 2, $urandom_range(99) < 5, $urandom_range(99) < 60,
              16'($urandom), 4'($urandom), $urandom_range(99) < 65, $urandom_range(99) < 3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
